// File: rtl/gyro_pkg.sv
// rtl/gyro_pkg.sv - shared states and constants for the gyro SPI burst reader
package gyro_pkg;
   typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, DONE} gyro_state_t;

   localparam logic [7:0] READ_FLAG   = 8'h80;
   localparam logic [7:0] GYRO_XOUT_H = 8'h43;
   localparam int         GYRO_BYTES  = 6;
   localparam int         FRAME_BITS  = 56;
endpackage

// File: rtl/spi_mode3_shifter.sv
// rtl/spi_mode3_shifter.sv - mode-3 SPI bit engine: one command byte out, GYRO_BYTES data bytes in
module spi_mode3_shifter
   import gyro_pkg::*;
#(
   parameter int CLK_DIV = 50
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [7:0]              cmd,
   input  logic                    spi_miso,
   output logic                    spi_sclk,
   output logic                    spi_mosi,
   output logic [GYRO_BYTES*8-1:0] rx_data,
   output logic                    done
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(FRAME_BITS + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(FRAME_BITS);

   logic                  active;
   logic [DW-1:0]         div_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] tx_sreg;
   logic                  phase_end;

   assign phase_end = active && (div_cnt == DIV_LAST);
   // done fires at the end of the high phase that follows the last rising edge
   assign done      = phase_end && spi_sclk && (bit_cnt == BITS_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active   <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_sreg  <= '0;
         rx_data  <= '0;
         spi_sclk <= 1'b1;
         spi_mosi <= 1'b0;
      end else if (start) begin
         active   <= 1'b1;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         spi_sclk <= 1'b0;
         spi_mosi <= cmd[7];
         tx_sreg  <= {cmd[6:0], {(FRAME_BITS - 7){1'b0}}};
      end else if (active) begin
         if (phase_end) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
               // 56 bits pass through a 48-bit register, so the command-byte echo falls off the top
               spi_sclk <= 1'b1;
               rx_data  <= {rx_data[GYRO_BYTES*8-2:0], spi_miso};
               bit_cnt  <= bit_cnt + 1'b1;
            end else if (done) begin
               active   <= 1'b0;
               spi_mosi <= 1'b0;
            end else begin
               spi_sclk <= 1'b0;
               spi_mosi <= tx_sreg[FRAME_BITS-1];
               tx_sreg  <= {tx_sreg[FRAME_BITS-2:0], 1'b0};
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/gyro_spi_reader.sv
// rtl/gyro_spi_reader.sv - periodic SPI burst read of IMU gyro rates into registered gx/gy/gz
module gyro_spi_reader
   import gyro_pkg::*;
#(
   parameter int         CLK_DIV       = 50,
   parameter int         SAMPLE_PERIOD = 100000,
   parameter logic [7:0] START_REG     = GYRO_XOUT_H
) (
   input  logic        clk_100mhz,
   input  logic        rst_in,
   input  logic        enable,
   input  logic        spi_miso,
   output logic        spi_sclk,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   output logic [15:0] gx,
   output logic [15:0] gy,
   output logic [15:0] gz,
   output logic        valid,
   output logic        busy,
   output logic        overrun
);
   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [TW-1:0] TICK_AT  = TW'(SAMPLE_PERIOD - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   gyro_state_t             state, state_next;
   logic [TW-1:0]           timer;
   logic [DW-1:0]           wait_cnt, wait_cnt_next;
   logic                    tick, shift_start, shift_done;
   logic [GYRO_BYTES*8-1:0] rx_data;

   assign tick = enable && (timer == TICK_AT);
   assign busy = ~spi_cs_n;

   spi_mode3_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk      (clk_100mhz),
      .rst      (rst_in),
      .start    (shift_start),
      .cmd      (START_REG | READ_FLAG),
      .spi_miso (spi_miso),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .rx_data  (rx_data),
      .done     (shift_done)
   );

   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         timer <= '0;
      end else if (!enable || tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      shift_start   = 1'b0;
      case (state)
         IDLE: begin
            if (tick) begin
               state_next    = CS_SETUP;
               wait_cnt_next = '0;
            end
         end
         CS_SETUP: begin
            if (wait_cnt == DIV_LAST) begin
               state_next  = XFER;
               shift_start = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         XFER: begin
            if (shift_done) begin
               state_next    = CS_HOLD;
               wait_cnt_next = '0;
            end
         end
         CS_HOLD: begin
            if (wait_cnt == DIV_LAST) begin
               state_next = DONE;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_100mhz or posedge rst_in) begin
      if (rst_in) begin
         state    <= IDLE;
         wait_cnt <= '0;
         spi_cs_n <= 1'b1;
         gx       <= '0;
         gy       <= '0;
         gz       <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         spi_cs_n <= !(state_next inside {CS_SETUP, XFER, CS_HOLD});
         valid    <= (state == DONE);
         overrun  <= tick && (state != IDLE);
         if (state == DONE) begin
            gx <= rx_data[47:32];
            gy <= rx_data[31:16];
            gz <= rx_data[15:0];
         end
      end
   end
endmodule

// File: tb/tb_gyro_spi_reader.sv
// tb/tb_gyro_spi_reader.sv - self-checking bench with mode-3 IMU slave model and sample scoreboard
module tb_gyro_spi_reader;
   localparam int LAT = 2 * 114 + 1;

   logic clk_100mhz = 1'b0;
   logic rst_in = 1'b1;
   logic enable_a = 1'b0, enable_b = 1'b0;
   logic miso_a = 1'b0, miso_b = 1'b1;
   logic sclk_a, cs_a, mosi_a, valid_a, busy_a, overrun_a;
   logic sclk_b, cs_b, mosi_b, valid_b, busy_b, overrun_b;
   logic [15:0] gx_a, gy_a, gz_a, gx_b, gy_b, gz_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   gyro_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(400), .START_REG(8'h43)) dut_a (
      .clk_100mhz(clk_100mhz), .rst_in(rst_in), .enable(enable_a), .spi_miso(miso_a),
      .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
      .gx(gx_a), .gy(gy_a), .gz(gz_a), .valid(valid_a), .busy(busy_a), .overrun(overrun_a));

   gyro_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .START_REG(8'h43)) dut_b (
      .clk_100mhz(clk_100mhz), .rst_in(rst_in), .enable(enable_b), .spi_miso(miso_b),
      .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
      .gx(gx_b), .gy(gy_b), .gz(gz_b), .valid(valid_b), .busy(busy_b), .overrun(overrun_b));

   // IMU slave: loads the next pattern on cs_n fall (sclk idle high), shifts out on sclk fall
   logic [47:0] pat [0:63];
   logic [55:0] slave_sreg = '0;
   int          slave_frame = 0;
   always @(negedge cs_a or negedge sclk_a) begin
      if (sclk_a) begin
         slave_sreg  <= {8'h00, pat[slave_frame % 64]};
         slave_frame <= slave_frame + 1;
      end else if (!cs_a) begin
         miso_a     <= slave_sreg[55];
         slave_sreg <= {slave_sreg[54:0], 1'b0};
      end
   end

   int cyc = 0;
   always @(posedge clk_100mhz) cyc <= cyc + 1;

   logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b1, prev_mosi_a = 1'b0, prev_valid_a = 1'b0;
   logic [47:0] prev_out_a = '0;
   int          fall_cyc_a = 0, first_fall_a = -1, rises_a = 0, frame_rises_a = 0;
   int          fs_a [0:63];
   int          fs_cnt_a = 0, valid_cnt_a = 0, valid_wide_a = 0;
   int          hold_viol_a = 0, mosi_viol_a = 0, idle_viol_a = 0;
   logic [55:0] mosi_cap_a = '0, frame_mosi_a = '0;
   logic [47:0] obs_data [0:63];
   int          obs_lat [0:63];
   int          obs_wr = 0, obs_rd = 0;
   logic [47:0] exp_q [$];

   always @(negedge clk_100mhz) begin
      if (!rst_in) begin
         if (prev_cs_a && !cs_a) begin
            fall_cyc_a          <= cyc;
            fs_a[fs_cnt_a % 64] <= cyc;
            fs_cnt_a            <= fs_cnt_a + 1;
            rises_a             <= 0;
            first_fall_a        <= -1;
            mosi_cap_a          <= '0;
         end
         if (!cs_a && prev_sclk_a && !sclk_a && first_fall_a < 0) first_fall_a <= cyc - fall_cyc_a;
         if (!cs_a && !prev_sclk_a && sclk_a) begin
            rises_a    <= rises_a + 1;
            mosi_cap_a <= {mosi_cap_a[54:0], mosi_a};
         end
         if (cs_a && !sclk_a) idle_viol_a <= idle_viol_a + 1;
         if (mosi_a !== prev_mosi_a && !(prev_sclk_a && !sclk_a)) mosi_viol_a <= mosi_viol_a + 1;
         if (valid_a) begin
            obs_data[obs_wr % 64] <= {gx_a, gy_a, gz_a};
            obs_lat[obs_wr % 64]  <= cyc - fall_cyc_a;
            obs_wr                <= obs_wr + 1;
            valid_cnt_a           <= valid_cnt_a + 1;
            frame_rises_a         <= rises_a;
            frame_mosi_a          <= mosi_cap_a;
            if (prev_valid_a) valid_wide_a <= valid_wide_a + 1;
         end else if ({gx_a, gy_a, gz_a} !== prev_out_a) begin
            hold_viol_a <= hold_viol_a + 1;
         end
      end
      prev_cs_a    <= cs_a;
      prev_sclk_a  <= sclk_a;
      prev_mosi_a  <= mosi_a;
      prev_valid_a <= valid_a;
      prev_out_a   <= {gx_a, gy_a, gz_a};
   end

   logic prev_cs_b = 1'b1;
   int   fs_b [0:7];
   int   fs_cnt_b = 0, valid_cnt_b = 0, ovr_cnt_b = 0, ovr_cyc_b = 0;
   always @(negedge clk_100mhz) begin
      if (!rst_in) begin
         if (prev_cs_b && !cs_b) begin
            fs_b[fs_cnt_b % 8] <= cyc;
            fs_cnt_b           <= fs_cnt_b + 1;
         end
         if (valid_b) valid_cnt_b <= valid_cnt_b + 1;
         if (overrun_b) begin
            ovr_cnt_b <= ovr_cnt_b + 1;
            ovr_cyc_b <= cyc;
         end
      end
      prev_cs_b <= cs_b;
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk_100mhz);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      tick_n(3);
      vectors++;
      if (cs_a !== 1'b1 || sclk_a !== 1'b1 || mosi_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pins: cs_n/sclk/mosi=%b%b%b expected 110", cs_a, sclk_a, mosi_a);
      end
      vectors++;
      if ({gx_a, gy_a, gz_a} !== 48'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: %h expected 0", {gx_a, gy_a, gz_a});
      end
      vectors++;
      if ({valid_a, busy_a, overrun_a} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: valid/busy/overrun=%b expected 000", {valid_a, busy_a, overrun_a});
      end
      rst_in = 1'b0;
      tick_n(2);
   endtask

   task automatic test_single_read();
      int t, n0, v0;
      logic [47:0] e;
      pat[slave_frame % 64] = 48'h1234_FF38_0007;
      exp_q.push_back(48'h1234_FF38_0007);
      v0 = valid_cnt_a;
      n0 = cyc;
      enable_a = 1'b1;
      t = 0;
      while (valid_cnt_a == v0 && t < 1000) begin tick_n(1); t++; end
      enable_a = 1'b0;
      tick_n(2);
      vectors++;
      if (valid_cnt_a != v0 + 1) begin
         miscompares++;
         $display("FAIL single_valid: %0d pulses expected 1", valid_cnt_a - v0);
      end
      vectors++;
      if (fs_a[(fs_cnt_a - 1) % 64] - n0 != 400) begin
         miscompares++;
         $display("FAIL first_frame_start: %0d expected 400", fs_a[(fs_cnt_a - 1) % 64] - n0);
      end
      vectors++;
      if ($signed(gy_a) != -200) begin
         miscompares++;
         $display("FAIL gy_signed: %0d expected -200", $signed(gy_a));
      end
      while (obs_rd < obs_wr) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_single: unexpected sample %h", obs_data[obs_rd % 64]);
         end else begin
            e = exp_q.pop_front();
            if (obs_data[obs_rd % 64] !== e) begin
               miscompares++;
               $display("FAIL sb_single: got %h expected %h", obs_data[obs_rd % 64], e);
            end
         end
         vectors++;
         if (obs_lat[obs_rd % 64] != LAT) begin
            miscompares++;
            $display("FAIL latency_single: %0d expected %0d", obs_lat[obs_rd % 64], LAT);
         end
         obs_rd++;
      end
   endtask

   task automatic test_sclk_framing();
      vectors++;
      if (frame_rises_a != 56) begin
         miscompares++;
         $display("FAIL sclk_rises: %0d expected 56", frame_rises_a);
      end
      vectors++;
      if (first_fall_a != 2) begin
         miscompares++;
         $display("FAIL cs_to_first_fall: %0d expected 2", first_fall_a);
      end
      vectors++;
      if (frame_mosi_a !== {8'hC3, 48'h0}) begin
         miscompares++;
         $display("FAIL mosi_frame: %h expected %h", frame_mosi_a, {8'hC3, 48'h0});
      end
      vectors++;
      if (idle_viol_a != 0 || mosi_viol_a != 0) begin
         miscompares++;
         $display("FAIL sclk_idle_mosi_stable: idle=%0d mosi=%0d expected 0 0", idle_viol_a, mosi_viol_a);
      end
   endtask

   task automatic test_periodic();
      int t, n0, v0, f0;
      logic [47:0] e;
      for (int k = 0; k < 3; k++) begin
         e = 48'({$urandom(), $urandom()});
         pat[(slave_frame + k) % 64] = e;
         exp_q.push_back(e);
      end
      v0 = valid_cnt_a;
      f0 = fs_cnt_a;
      n0 = cyc;
      enable_a = 1'b1;
      tick_n(1200);
      enable_a = 1'b0;
      t = 0;
      while (valid_cnt_a < v0 + 3 && t < 600) begin tick_n(1); t++; end
      tick_n(300);
      vectors++;
      if (fs_cnt_a != f0 + 3 || valid_cnt_a != v0 + 3) begin
         miscompares++;
         $display("FAIL periodic_count: frames=%0d valids=%0d expected 3 3", fs_cnt_a - f0, valid_cnt_a - v0);
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (fs_a[(f0 + k) % 64] - n0 != 400 * (k + 1)) begin
            miscompares++;
            $display("FAIL periodic_start%0d: %0d expected %0d", k, fs_a[(f0 + k) % 64] - n0, 400 * (k + 1));
         end
      end
      vectors++;
      if (hold_viol_a != 0 || valid_wide_a != 0) begin
         miscompares++;
         $display("FAIL output_hold: changes=%0d wide=%0d expected 0 0", hold_viol_a, valid_wide_a);
      end
      while (obs_rd < obs_wr) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_periodic: unexpected sample %h", obs_data[obs_rd % 64]);
         end else begin
            e = exp_q.pop_front();
            if (obs_data[obs_rd % 64] !== e) begin
               miscompares++;
               $display("FAIL sb_periodic: got %h expected %h", obs_data[obs_rd % 64], e);
            end
         end
         vectors++;
         if (obs_lat[obs_rd % 64] != LAT) begin
            miscompares++;
            $display("FAIL latency_periodic: %0d expected %0d", obs_lat[obs_rd % 64], LAT);
         end
         obs_rd++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_periodic_missing: %0d samples expected 0", exp_q.size());
      end
   endtask

   task automatic test_overrun();
      int n0;
      n0 = cyc;
      enable_b = 1'b1;
      tick_n(650);
      enable_b = 1'b0;
      tick_n(400);
      vectors++;
      if (fs_cnt_b != 2 || valid_cnt_b != 2) begin
         miscompares++;
         $display("FAIL overrun_frames: frames=%0d valids=%0d expected 2 2", fs_cnt_b, valid_cnt_b);
      end
      vectors++;
      if (fs_b[0] - n0 != 200 || fs_b[1] - n0 != 600) begin
         miscompares++;
         $display("FAIL overrun_starts: %0d %0d expected 200 600", fs_b[0] - n0, fs_b[1] - n0);
      end
      vectors++;
      if (ovr_cnt_b != 1 || ovr_cyc_b - n0 != 400) begin
         miscompares++;
         $display("FAIL overrun_pulse: count=%0d at=%0d expected 1 at 400", ovr_cnt_b, ovr_cyc_b - n0);
      end
      vectors++;
      if ({gx_b, gy_b, gz_b} !== 48'hFFFF_FFFF_FFFF) begin
         miscompares++;
         $display("FAIL overrun_data: %h expected ffffffffffff", {gx_b, gy_b, gz_b});
      end
   endtask

   task automatic test_reset_mid_frame();
      int t, n0, v0, f0;
      logic [47:0] e;
      pat[slave_frame % 64]       = 48'hDEAD_BEEF_0BAD;
      pat[(slave_frame + 1) % 64] = 48'h8000_7FFF_00FF;
      exp_q.push_back(48'h8000_7FFF_00FF);
      v0 = valid_cnt_a;
      f0 = fs_cnt_a;
      enable_a = 1'b1;
      t = 0;
      while (fs_cnt_a == f0 && t < 600) begin tick_n(1); t++; end
      t = 0;
      while (rises_a < 30 && t < 300) begin tick_n(1); t++; end
      vectors++;
      if (rises_a != 30) begin
         miscompares++;
         $display("FAIL reset_mid_reach: reached bit %0d expected 30", rises_a);
      end
      rst_in = 1'b1;
      #1;
      vectors++;
      if (cs_a !== 1'b1 || sclk_a !== 1'b1 || busy_a !== 1'b0 || {gx_a, gy_a, gz_a} !== 48'h0) begin
         miscompares++;
         $display("FAIL reset_mid_state: cs_n=%b sclk=%b busy=%b out=%h expected 1 1 0 0",
                  cs_a, sclk_a, busy_a, {gx_a, gy_a, gz_a});
      end
      tick_n(3);
      rst_in = 1'b0;
      n0 = cyc;
      t = 0;
      while (valid_cnt_a == v0 && t < 1000) begin tick_n(1); t++; end
      enable_a = 1'b0;
      tick_n(2);
      vectors++;
      if (valid_cnt_a != v0 + 1 || fs_a[(fs_cnt_a - 1) % 64] - n0 != 400) begin
         miscompares++;
         $display("FAIL reset_recovery: valids=%0d start=%0d expected 1 400",
                  valid_cnt_a - v0, fs_a[(fs_cnt_a - 1) % 64] - n0);
      end
      vectors++;
      if (frame_rises_a != 56) begin
         miscompares++;
         $display("FAIL reset_recovery_rises: %0d expected 56", frame_rises_a);
      end
      while (obs_rd < obs_wr) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_reset: unexpected sample %h", obs_data[obs_rd % 64]);
         end else begin
            e = exp_q.pop_front();
            if (obs_data[obs_rd % 64] !== e) begin
               miscompares++;
               $display("FAIL sb_reset: got %h expected %h", obs_data[obs_rd % 64], e);
            end
         end
         obs_rd++;
      end
   endtask

   task automatic test_enable_drop();
      int t, v0, f0;
      logic [47:0] e;
      pat[slave_frame % 64] = 48'h0102_0304_0506;
      exp_q.push_back(48'h0102_0304_0506);
      v0 = valid_cnt_a;
      f0 = fs_cnt_a;
      enable_a = 1'b1;
      t = 0;
      while (fs_cnt_a == f0 && t < 600) begin tick_n(1); t++; end
      t = 0;
      while (rises_a < 10 && t < 300) begin tick_n(1); t++; end
      enable_a = 1'b0;
      t = 0;
      while (valid_cnt_a == v0 && t < 600) begin tick_n(1); t++; end
      tick_n(1000);
      vectors++;
      if (fs_cnt_a != f0 + 1 || valid_cnt_a != v0 + 1) begin
         miscompares++;
         $display("FAIL enable_drop: frames=%0d valids=%0d expected 1 1", fs_cnt_a - f0, valid_cnt_a - v0);
      end
      while (obs_rd < obs_wr) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_enable_drop: unexpected sample %h", obs_data[obs_rd % 64]);
         end else begin
            e = exp_q.pop_front();
            if (obs_data[obs_rd % 64] !== e) begin
               miscompares++;
               $display("FAIL sb_enable_drop: got %h expected %h", obs_data[obs_rd % 64], e);
            end
         end
         vectors++;
         if (obs_lat[obs_rd % 64] != LAT) begin
            miscompares++;
            $display("FAIL latency_enable_drop: %0d expected %0d", obs_lat[obs_rd % 64], LAT);
         end
         obs_rd++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_enable_drop_missing: %0d samples expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_sclk_framing();
      test_periodic();
      test_overrun();
      test_reset_mid_frame();
      test_enable_drop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
